shift_sipo_rx: RTL
==================

Name: shift_sipo_rx

Overview:
- Serial-in/parallel-out receiver; the receiving end of the team's bit-shift datapath.
- Collects a serial bitstream of programmable length (1..8 bits) and direction into a right-justified 8-bit word.
- Presents the word on a valid/ready output handshake.
- Sits between a serial link/shifter output and the 8-bit parallel datapath that consumes words.

Parameters:
W, 8, parallel word width; n width is clog2(W)=3. Only W=8 is required to be supported.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
sin  input  1  serial data bit
sin_valid  input  1  sin is sampled on clk edges where sin_valid=1
d  input  1  bit order: 0 = MSB-first (left-shift in), 1 = LSB-first (right-shift in)
n  input  3  frame length minus 1 (n=0 -> 1 bit, n=7 -> 8 bits)
x  output  8  received word, right-justified, unused upper bits 0
x_valid  output  1  x holds an unconsumed word
x_ready  input  1  consumer accepts x when x_valid & x_ready at a clk edge
busy  output  1  frame in progress (at least 1 bit collected, frame incomplete)
ovf  output  1  one-cycle pulse: completed word dropped because x was occupied

Behaviour:
- Reset (async, any time including mid-frame): x=0, x_valid=0, busy=0, ovf=0, bit counter=0, shift register=0, partial frame discarded.
- States:
  - IDLE (busy=0): the first edge with sin_valid=1 latches d and n into d_l/n_l, clears the shift register, and shifts in sin. It then goes to COLLECT, or completes immediately if n=0.
  - COLLECT (busy=1): each sin_valid edge shifts in one bit and increments cnt. Edges with sin_valid=0 hold all state; gaps are unlimited.
- Shift rules:
  - d_l=0: sr <= {sr[6:0], sin}.
  - d_l=1: sr <= {sin, sr[7:1]}.
- d and n are ignored after the first bit of a frame. Changes mid-frame take effect at the next frame.
- Completion happens on the edge that accepts bit number n_l+1. The completed word cw is:
  - d_l=0: the shift register result, already right-justified.
  - d_l=1: the shift register result shifted right by (7-n_l).
- Upper bits above n_l are 0 in both cases.
- At the completion edge, if x_valid=0 or x_ready=1:
  - x<=cw and x_valid<=1.
  - x_valid is visible the cycle after the last bit is sampled (latency 1 edge).
- At the completion edge, if x_valid=1 and x_ready=0:
  - cw is discarded; x and x_valid are unchanged.
  - ovf=1 for exactly one cycle.
- The FSM returns to IDLE at the completion edge in both cases. A bit on the next edge starts a new frame, so back-to-back frames run with no dead cycle.
- An edge with x_valid=1, x_ready=1 and no completion: x_valid<=0 and x keeps its value.
- Collection proceeds independently of output backpressure, acting as a 1-deep output buffer plus an in-flight shift register.
- x_ready while x_valid=0 has no effect.
- Implementation: 3-bit counter, 8-bit shift register, 8-bit output register. No combinational path from sin to x.

Test Plan:
- Reset, then d=0, n=7, bits 0,0,0,1,0,0,0,0 on consecutive edges, x_ready=1 -> x=8'h10, x_valid high one cycle after the 8th bit, busy high during bits 1..7.
- d=1, n=7, same bit sequence in the same time order -> x=8'h08.
- n=2, bits 1,1,0: with d=0 -> x=8'h06; with d=1 -> x=8'h03. Upper 5 bits are 0 in both cases.
- n=0, d=0, sin=1 on a single edge -> x=8'h01 one edge later, busy never asserts; the next edge's bit starts a new frame.
- Hold x_ready=0, send two n=7, d=0 frames 8'hA5 then 8'h3C:
  - x stays 8'hA5 and ovf pulses once at the 16th bit.
  - Then x_ready=1 for one edge -> x_valid=0.
- Send 4 bits with sin_valid gaps of 3 cycles, assert rst mid-frame -> all outputs 0 immediately, busy=0.
  - Then a fresh d=0, n=3 frame with bits 1,0,0,1 -> x=8'h09.
  - d/n toggled mid-frame do not change this result.

Source files
------------

// File: rtl/shift_sipo_rx.sv
// Serial-in/parallel-out receiver. Collects a frame of 1..W serial bits,
// either MSB-first or LSB-first, into a right-justified word. The word is
// handed to the consumer through a one-deep valid/ready output register.
// A word that completes while the output register is still occupied is
// dropped, and ovf is raised for one cycle.
module shift_sipo_rx #(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sin,
  input  logic                 sin_valid,
  input  logic                 d,
  input  logic [$clog2(W)-1:0] n,
  output logic [W-1:0]         x,
  output logic                 x_valid,
  input  logic                 x_ready,
  output logic                 busy,
  output logic                 ovf
);

  localparam int NW = $clog2(W);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [NW-1:0]   cnt_q, cnt_d;      // bits already collected in this frame
  logic [W-1:0]    sr_q, sr_d;        // in-flight shift register
  logic            d_l_q, d_l_d;      // bit order latched at first bit
  logic [NW-1:0]   n_l_q, n_l_d;      // frame length - 1 latched at first bit
  logic [W-1:0]    x_q, x_d;          // output word register
  logic            x_valid_q, x_valid_d;
  logic            ovf_q, ovf_d;

  // Settings and base register for the bit arriving on this edge. The first
  // bit of a frame uses the live d/n and starts from an empty register.
  logic            d_sel;
  logic [NW-1:0]   n_sel;
  logic [W-1:0]    sr_base;
  logic [W-1:0]    sr_shift;
  logic [NW-1:0]   bits_before;
  logic [NW-1:0]   shamt;
  logic            done;
  logic [W-1:0]    cw;

  // State register: all control and data flops, asynchronously cleared.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      d_l_q     <= 1'b0;
      n_l_q     <= '0;
      x_q       <= '0;
      x_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      d_l_q     <= d_l_d;
      n_l_q     <= n_l_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      ovf_q     <= ovf_d;
    end
  end

  // Next-state: shift in accepted bits, detect frame completion, and manage
  // the output register handshake.
  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    d_l_d       = d_l_q;
    n_l_d       = n_l_q;
    x_d         = x_q;
    x_valid_d   = x_valid_q;
    ovf_d       = 1'b0;
    done        = 1'b0;

    d_sel       = (state_q == IDLE) ? d : d_l_q;
    n_sel       = (state_q == IDLE) ? n : n_l_q;
    sr_base     = (state_q == IDLE) ? '0 : sr_q;
    bits_before = (state_q == IDLE) ? '0 : cnt_q;
    sr_shift    = d_sel ? {sin, sr_base[W-1:1]} : {sr_base[W-2:0], sin};

    // LSB-first frames fill from the top and need aligning down to bit 0.
    shamt       = NW'(W - 1) - n_sel;
    cw          = d_sel ? (sr_shift >> shamt) : sr_shift;

    if (sin_valid) begin
      sr_d  = sr_shift;
      d_l_d = d_sel;
      n_l_d = n_sel;
      done  = (bits_before == n_sel);
      if (done) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = COLLECT;
        cnt_d   = bits_before + NW'(1);
      end
    end

    if (done) begin
      if (!x_valid_q || x_ready) begin
        x_d       = cw;
        x_valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (x_valid_q && x_ready) begin
      x_valid_d = 1'b0;
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign busy    = (state_q == COLLECT);
  assign ovf     = ovf_q;

endmodule
